mci_lc_otp_prog_resp: RTL and testbench

// - OTP-side responder for the LCC program interface. Produces the otp_lc_data (valid/state/count) view that the LCC and the MCI state translator consume.
// - Boot: reads the LC partition from the fuse macro word-by-word, then asserts valid.
// - Runtime: accepts one LCC program request per power cycle and writes only the changed words (OR-only).
// - Answers the request with a one-cycle ack/err pulse.

---
 rtl/mci_lc_otp_prog_resp_pkg.sv | 21 ++
 rtl/mci_lc_otp_prog_resp_if.sv | 18 +
 rtl/mci_lc_otp_prog_resp.sv | 214 +++++++++++++++++++++
 tb/tb_mci_lc_otp_prog_resp.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mci_lc_otp_prog_resp_pkg.sv
// Shared types and constants for the OTP-side LC program responder.
package mci_lc_otp_prog_resp_pkg;

  localparam int MCI_LC_OTP_STATE_W   = 320;
  localparam int MCI_LC_OTP_CNT_W     = 384;
  localparam int MCI_LC_OTP_WORD_W    = 16;
  localparam int MCI_LC_OTP_NUM_WORDS = (MCI_LC_OTP_STATE_W + MCI_LC_OTP_CNT_W) / MCI_LC_OTP_WORD_W;
  localparam int MCI_LC_OTP_ADDR_W    = 6;

  // Responder FSM; BOOT_RD is the all-zero reset encoding.
  typedef enum logic [2:0] {
    LC_OTP_BOOT_RD    = 3'd0,
    LC_OTP_IDLE       = 3'd1,
    LC_OTP_CHECK      = 3'd2,
    LC_OTP_WRITE      = 3'd3,
    LC_OTP_RESP       = 3'd4,
    LC_OTP_WAIT_DROP  = 3'd5,
    LC_OTP_LOCKED_ERR = 3'd6
  } mci_lc_otp_resp_fsm_e;

endpackage

// File: rtl/mci_lc_otp_prog_resp_if.sv
// Fuse macro word-access bus: one request outstanding, held until ack.
interface mci_lc_otp_prog_resp_if
  import mci_lc_otp_prog_resp_pkg::*;
#(
  parameter int WORD_W = MCI_LC_OTP_WORD_W,
  parameter int ADDR_W = MCI_LC_OTP_ADDR_W
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [WORD_W-1:0] wdata;
  logic              ack;
  logic [WORD_W-1:0] rdata;
  logic              err;

  modport master (output req, we, addr, wdata, input ack, rdata, err);
  modport slave  (input req, we, addr, wdata, output ack, rdata, err);
endinterface

// File: rtl/mci_lc_otp_prog_resp.sv
// OTP-side responder for the LCC program interface: boots the LC partition
// shadow from the fuse macro, then serves one OR-only program request per
// power cycle with a single ack/err pulse.
module mci_lc_otp_prog_resp
  import mci_lc_otp_prog_resp_pkg::*;
#(
  parameter int STATE_W   = MCI_LC_OTP_STATE_W,
  parameter int CNT_W     = MCI_LC_OTP_CNT_W,
  parameter int WORD_W    = MCI_LC_OTP_WORD_W,
  parameter int BASE_ADDR = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  lc_prog_req_i,
  input  logic [STATE_W-1:0]    lc_prog_state_i,
  input  logic [CNT_W-1:0]      lc_prog_count_i,
  output logic                  lc_prog_ack_o,
  output logic                  lc_prog_err_o,
  output logic                  otp_lc_valid_o,
  output logic [STATE_W-1:0]    otp_lc_state_o,
  output logic [CNT_W-1:0]      otp_lc_count_o,
  mci_lc_otp_prog_resp_if.master macro,
  output logic                  fatal_err_o
);

  localparam int NW     = (STATE_W + CNT_W) / WORD_W;
  localparam int IDX_W  = $clog2(NW);
  localparam int ADDR_W = MCI_LC_OTP_ADDR_W;

  mci_lc_otp_resp_fsm_e state_q, state_d;

  logic [IDX_W-1:0]           idx_q;
  logic                       req_q;
  logic                       done_q;
  logic                       err_q;
  logic                       valid_q;
  logic                       fatal_q;
  logic                       lock_ack_q;
  logic                       lock_seen_q;
  logic [NW-1:0][WORD_W-1:0]  shadow_q;
  logic [NW-1:0][WORD_W-1:0]  tgt_q;
  logic [NW*WORD_W-1:0]       shadow_flat;
  logic [NW*WORD_W-1:0]       tgt_flat;

  logic [WORD_W-1:0] shadow_word;
  logic [WORD_W-1:0] tgt_word;
  logic              last_idx;
  logic              clr_viol;

  logic idx_clr, idx_inc, req_set, req_clr, store_rd, latch_tgt;
  logic err_set, err_clr, done_set, fatal_set, valid_set, lock_ack_d;

  assign shadow_flat = shadow_q;
  assign tgt_flat    = tgt_q;
  assign last_idx    = (idx_q == IDX_W'(NW - 1));
  // Any bit that is burnt in the fuse but cleared in the target cannot be programmed.
  assign clr_viol    = |(shadow_flat & ~tgt_flat);

  // Word-select mux: current shadow and target word at the scan index.
  always_comb begin
    shadow_word = shadow_q[idx_q];
    tgt_word    = tgt_q[idx_q];
  end

  assign macro.req   = req_q;
  assign macro.we    = (state_q == LC_OTP_WRITE);
  assign macro.addr  = ADDR_W'(BASE_ADDR + int'(idx_q));
  assign macro.wdata = (state_q == LC_OTP_WRITE) ? tgt_word : '0;

  assign otp_lc_valid_o = valid_q;
  assign otp_lc_state_o = shadow_flat[STATE_W-1:0];
  assign otp_lc_count_o = shadow_flat[STATE_W +: CNT_W];
  assign fatal_err_o    = fatal_q;
  assign lc_prog_ack_o  = (state_q == LC_OTP_RESP) | lock_ack_q;
  assign lc_prog_err_o  = (state_q == LC_OTP_RESP) ? err_q : lock_ack_q;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= LC_OTP_BOOT_RD;
    else        state_q <= state_d;
  end

  // Next-state logic and per-cycle control strobes for the datapath registers.
  always_comb begin
    state_d    = state_q;
    idx_clr    = 1'b0;
    idx_inc    = 1'b0;
    req_set    = 1'b0;
    req_clr    = 1'b0;
    store_rd   = 1'b0;
    latch_tgt  = 1'b0;
    err_set    = 1'b0;
    err_clr    = 1'b0;
    done_set   = 1'b0;
    fatal_set  = 1'b0;
    valid_set  = 1'b0;
    lock_ack_d = 1'b0;
    unique case (state_q)
      LC_OTP_BOOT_RD: begin
        if (!req_q) begin
          req_set = 1'b1;
        end else if (macro.ack) begin
          req_clr = 1'b1;
          if (macro.err) begin
            fatal_set = 1'b1;
            state_d   = LC_OTP_LOCKED_ERR;
          end else begin
            store_rd = 1'b1;
            if (last_idx) begin
              valid_set = 1'b1;
              idx_clr   = 1'b1;
              state_d   = LC_OTP_IDLE;
            end else begin
              idx_inc = 1'b1;
            end
          end
        end
      end
      LC_OTP_IDLE: begin
        if (lc_prog_req_i) begin
          latch_tgt = 1'b1;
          state_d   = LC_OTP_CHECK;
        end
      end
      LC_OTP_CHECK: begin
        if (done_q || clr_viol) begin
          err_set = 1'b1;
          state_d = LC_OTP_RESP;
        end else begin
          idx_clr = 1'b1;
          state_d = LC_OTP_WRITE;
        end
      end
      LC_OTP_WRITE: begin
        // Unchanged words are skipped without touching the macro.
        if (!req_q) begin
          if (tgt_word == shadow_word) begin
            if (last_idx) begin
              err_clr  = 1'b1;
              done_set = 1'b1;
              state_d  = LC_OTP_RESP;
            end else begin
              idx_inc = 1'b1;
            end
          end else begin
            req_set = 1'b1;
          end
        end else if (macro.ack) begin
          req_clr = 1'b1;
          if (macro.err) begin
            // Abort: the partition is now in an unknown state, so no retry this power cycle.
            err_set   = 1'b1;
            fatal_set = 1'b1;
            done_set  = 1'b1;
            state_d   = LC_OTP_RESP;
          end else if (last_idx) begin
            err_clr  = 1'b1;
            done_set = 1'b1;
            state_d  = LC_OTP_RESP;
          end else begin
            idx_inc = 1'b1;
          end
        end
      end
      LC_OTP_RESP: begin
        state_d = LC_OTP_WAIT_DROP;
      end
      LC_OTP_WAIT_DROP: begin
        if (!lc_prog_req_i) state_d = LC_OTP_IDLE;
      end
      LC_OTP_LOCKED_ERR: begin
        // Ack each rising request with an error; no macro traffic.
        lock_ack_d = lc_prog_req_i && !lock_seen_q;
      end
      default: begin
        state_d = LC_OTP_LOCKED_ERR;
      end
    endcase
  end

  // Control registers and boot shadow, updated from the FSM strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q       <= '0;
      req_q       <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      valid_q     <= 1'b0;
      fatal_q     <= 1'b0;
      lock_ack_q  <= 1'b0;
      lock_seen_q <= 1'b0;
      shadow_q    <= '0;
    end else begin
      if (idx_clr)      idx_q <= '0;
      else if (idx_inc) idx_q <= idx_q + 1'b1;
      if (req_set)      req_q <= 1'b1;
      else if (req_clr) req_q <= 1'b0;
      if (store_rd)     shadow_q[idx_q] <= macro.rdata;
      if (err_set)      err_q <= 1'b1;
      else if (err_clr) err_q <= 1'b0;
      if (done_set)     done_q  <= 1'b1;
      if (fatal_set)    fatal_q <= 1'b1;
      if (valid_set)    valid_q <= 1'b1;
      lock_ack_q  <= lock_ack_d;
      lock_seen_q <= (state_q == LC_OTP_LOCKED_ERR) && lc_prog_req_i;
    end
  end

  // Target latch for the request being served.
  always_ff @(posedge clk) begin
    if (latch_tgt) tgt_q <= {lc_prog_count_i, lc_prog_state_i};
  end

endmodule

// File: tb/tb_mci_lc_otp_prog_resp.sv
// Directed bench for the LC OTP program responder with a behavioural fuse macro.
module tb_mci_lc_otp_prog_resp;
  import mci_lc_otp_prog_resp_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         lc_prog_req = 1'b0;
  logic [319:0] st_i = '0;
  logic [383:0] cnt_i = '0;
  logic         ack, err, valid, fatal;
  logic [319:0] st_o;
  logic [383:0] cnt_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mci_lc_otp_prog_resp_if #(.WORD_W(16), .ADDR_W(6)) macro ();

  mci_lc_otp_prog_resp #(.STATE_W(320), .CNT_W(384), .WORD_W(16), .BASE_ADDR(0)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .lc_prog_req_i   (lc_prog_req),
    .lc_prog_state_i (st_i),
    .lc_prog_count_i (cnt_i),
    .lc_prog_ack_o   (ack),
    .lc_prog_err_o   (err),
    .otp_lc_valid_o  (valid),
    .otp_lc_state_o  (st_o),
    .otp_lc_count_o  (cnt_o),
    .macro           (macro),
    .fatal_err_o     (fatal)
  );

  // Behavioural fuse macro.
  logic [15:0] mem [64];
  int          lat = 2;
  int          rd_err_addr = -1;
  int          wr_err_addr = -1;
  int          mcnt;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  int          req_cyc = 0;
  logic [5:0]  wr_addr_log [256];
  logic [15:0] wr_data_log [256];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      macro.ack   <= 1'b0;
      macro.err   <= 1'b0;
      macro.rdata <= '0;
      mcnt        <= 0;
    end else if (macro.ack) begin
      macro.ack <= 1'b0;
      macro.err <= 1'b0;
    end else if (macro.req) begin
      if (mcnt >= lat - 1) begin
        mcnt        <= 0;
        macro.ack   <= 1'b1;
        macro.rdata <= mem[macro.addr];
        if (macro.we) begin
          macro.err <= (int'(macro.addr) == wr_err_addr);
          wr_addr_log[wr_cnt[7:0]] <= macro.addr;
          wr_data_log[wr_cnt[7:0]] <= macro.wdata;
          wr_cnt <= wr_cnt + 1;
        end else begin
          macro.err <= (int'(macro.addr) == rd_err_addr);
          rd_cnt <= rd_cnt + 1;
        end
      end else begin
        mcnt <= mcnt + 1;
      end
    end
  end

  always @(posedge clk) begin
    if (macro.req) req_cyc <= req_cyc + 1;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [703:0] exp_v;
  logic [703:0] tgt;

  task automatic load_pattern();
    for (int i = 0; i < 64; i++) mem[i] = 16'h1111 * 16'(i % 4);
  endtask

  task automatic build_exp();
    for (int i = 0; i < 44; i++) exp_v[i*16 +: 16] = mem[i];
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    lc_prog_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_boot(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (valid || fatal) begin ok = 1'b1; break; end
    end
  endtask

  task automatic do_req(input logic [703:0] t, input int max_cyc, output bit got, output logic e);
    got = 1'b0;
    e = 1'b0;
    @(negedge clk);
    st_i = t[319:0];
    cnt_i = t[703:320];
    lc_prog_req = 1'b1;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (ack) begin got = 1'b1; e = err; break; end
    end
  endtask

  task automatic drop_req();
    lc_prog_req = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    load_pattern();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++; if ({valid, ack, err, fatal, macro.req} !== 5'b0) begin n_bad++; $display("FAIL reset_ctrl: got %b want 00000", {valid, ack, err, fatal, macro.req}); end
    n_cmp++; if ({cnt_o, st_o} !== 704'b0) begin n_bad++; $display("FAIL reset_shadow: got nonzero shadow %h", st_o); end
  endtask

  task automatic test_boot();
    bit ok;
    int rd0;
    load_pattern();
    build_exp();
    rd0 = rd_cnt;
    rst_n = 1'b1;
    wait_boot(2000, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL boot_timeout: valid=%b want 1", valid); end
    n_cmp++; if ({valid, fatal} !== 2'b10) begin n_bad++; $display("FAIL boot_flags: valid/fatal=%b want 10", {valid, fatal}); end
    n_cmp++; if (st_o !== exp_v[319:0]) begin n_bad++; $display("FAIL boot_state: got %h want %h", st_o, exp_v[319:0]); end
    n_cmp++; if (cnt_o !== exp_v[703:320]) begin n_bad++; $display("FAIL boot_count: got %h want %h", cnt_o, exp_v[703:320]); end
    n_cmp++; if (rd_cnt - rd0 !== 44) begin n_bad++; $display("FAIL boot_reads: got %0d want 44", rd_cnt - rd0); end
  endtask

  task automatic test_or_write();
    bit got;
    logic e;
    int w0, extra;
    tgt = exp_v;
    tgt[3*16 +: 16]  = 16'h3337;
    tgt[25*16 +: 16] = 16'h1113;
    w0 = wr_cnt;
    do_req(tgt, 600, got, e);
    n_cmp++; if ({got, e} !== 2'b10) begin n_bad++; $display("FAIL or_ack: got/err=%b want 10", {got, e}); end
    n_cmp++; if (wr_cnt - w0 !== 2) begin n_bad++; $display("FAIL or_nwrites: got %0d want 2", wr_cnt - w0); end
    n_cmp++; if ({wr_addr_log[w0[7:0]], wr_data_log[w0[7:0]]} !== {6'd3, 16'h3337}) begin n_bad++; $display("FAIL or_write0: got %0d/%h want 3/3337", wr_addr_log[w0[7:0]], wr_data_log[w0[7:0]]); end
    n_cmp++; if ({wr_addr_log[8'(w0 + 1)], wr_data_log[8'(w0 + 1)]} !== {6'd25, 16'h1113}) begin n_bad++; $display("FAIL or_write1: got %0d/%h want 25/1113", wr_addr_log[8'(w0 + 1)], wr_data_log[8'(w0 + 1)]); end
    n_cmp++; if ({cnt_o, st_o} !== exp_v) begin n_bad++; $display("FAIL or_shadow_static: state got %h want %h", st_o, exp_v[319:0]); end
    // Request stays high: no second ack.
    extra = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ack) extra++;
    end
    n_cmp++; if (extra !== 0) begin n_bad++; $display("FAIL held_req_acks: got %0d extra acks want 0", extra); end
    drop_req();
  endtask

  task automatic test_after_done();
    bit got;
    logic e;
    int w0, r0;
    w0 = wr_cnt;
    r0 = req_cyc;
    do_req(tgt, 50, got, e);
    n_cmp++; if ({got, e} !== 2'b11) begin n_bad++; $display("FAIL second_req: got/err=%b want 11", {got, e}); end
    n_cmp++; if (req_cyc - r0 !== 0) begin n_bad++; $display("FAIL second_req_macro: got %0d req cycles want 0", req_cyc - r0); end
    n_cmp++; if (wr_cnt - w0 !== 0) begin n_bad++; $display("FAIL second_req_writes: got %0d want 0", wr_cnt - w0); end
    drop_req();
  endtask

  task automatic test_clear_bit();
    bit ok, got;
    logic e;
    int w0;
    load_pattern();
    mem[0] = 16'h0001;
    build_exp();
    pulse_reset();
    wait_boot(2000, ok);
    n_cmp++; if ({ok, valid} !== 2'b11) begin n_bad++; $display("FAIL clr_boot: ok/valid=%b want 11", {ok, valid}); end
    tgt = exp_v;
    tgt[15:0] = 16'h0000;
    w0 = wr_cnt;
    do_req(tgt, 50, got, e);
    n_cmp++; if ({got, e} !== 2'b11) begin n_bad++; $display("FAIL clr_ack: got/err=%b want 11", {got, e}); end
    n_cmp++; if (wr_cnt - w0 !== 0) begin n_bad++; $display("FAIL clr_writes: got %0d want 0", wr_cnt - w0); end
    n_cmp++; if (fatal !== 1'b0) begin n_bad++; $display("FAIL clr_fatal: got %b want 0", fatal); end
    drop_req();
  endtask

  task automatic test_write_err();
    bit got;
    logic e;
    int w0;
    tgt = exp_v;
    tgt[5*16 +: 16]  = 16'h1119;
    tgt[9*16 +: 16]  = 16'h1311;
    tgt[12*16 +: 16] = 16'h8000;
    wr_err_addr = 9;
    w0 = wr_cnt;
    do_req(tgt, 600, got, e);
    n_cmp++; if ({got, e, fatal} !== 3'b111) begin n_bad++; $display("FAIL werr_ack: got/err/fatal=%b want 111", {got, e, fatal}); end
    n_cmp++; if (wr_cnt - w0 !== 2) begin n_bad++; $display("FAIL werr_nwrites: got %0d want 2", wr_cnt - w0); end
    n_cmp++; if ({wr_addr_log[w0[7:0]], wr_addr_log[8'(w0 + 1)]} !== {6'd5, 6'd9}) begin n_bad++; $display("FAIL werr_addrs: got %0d,%0d want 5,9", wr_addr_log[w0[7:0]], wr_addr_log[8'(w0 + 1)]); end
    drop_req();
    wr_err_addr = -1;
    w0 = wr_cnt;
    do_req(tgt, 50, got, e);
    n_cmp++; if ({got, e} !== 2'b11) begin n_bad++; $display("FAIL werr_retry: got/err=%b want 11", {got, e}); end
    n_cmp++; if (wr_cnt - w0 !== 0) begin n_bad++; $display("FAIL werr_retry_writes: got %0d want 0", wr_cnt - w0); end
    drop_req();
  endtask

  task automatic test_boot_err();
    bit ok;
    int r0, q0;
    load_pattern();
    rd_err_addr = 7;
    r0 = rd_cnt;
    pulse_reset();
    wait_boot(2000, ok);
    repeat (5) @(negedge clk);
    n_cmp++; if ({ok, valid, fatal} !== 3'b101) begin n_bad++; $display("FAIL berr_flags: ok/valid/fatal=%b want 101", {ok, valid, fatal}); end
    n_cmp++; if (rd_cnt - r0 !== 8) begin n_bad++; $display("FAIL berr_reads: got %0d want 8", rd_cnt - r0); end
    rd_err_addr = -1;
    q0 = req_cyc;
    lc_prog_req = 1'b1;
    @(negedge clk);
    n_cmp++; if ({ack, err} !== 2'b11) begin n_bad++; $display("FAIL locked_ack: ack/err=%b want 11", {ack, err}); end
    @(negedge clk);
    n_cmp++; if (ack !== 1'b0) begin n_bad++; $display("FAIL locked_pulse: ack=%b want 0", ack); end
    n_cmp++; if (req_cyc - q0 !== 0) begin n_bad++; $display("FAIL locked_macro: got %0d req cycles want 0", req_cyc - q0); end
    drop_req();
  endtask

  task automatic test_async_reset();
    bit ok, seen;
    load_pattern();
    build_exp();
    lat = 6;
    pulse_reset();
    wait_boot(4000, ok);
    tgt = exp_v;
    tgt[15:0] = 16'h0100;
    @(negedge clk);
    st_i = tgt[319:0];
    cnt_i = tgt[703:320];
    lc_prog_req = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (macro.req && macro.we) begin seen = 1'b1; break; end
    end
    n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL arst_write_start: seen=%b want 1", seen); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({macro.req, valid, ack} !== 3'b000) begin n_bad++; $display("FAIL arst_drop: req/valid/ack=%b want 000", {macro.req, valid, ack}); end
    lc_prog_req = 1'b0;
    lat = 2;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_boot();
    test_or_write();
    test_after_done();
    test_clear_bit();
    test_write_err();
    test_boot_err();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
